// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of a dual-clock FIFO. It synchronises the write Gray pointer,
// advances the read pointer and produces registered empty, almost-empty, count and underflow.
module fifo_rd_ctrl #(
  parameter int MEM_DEPTH   = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
  input  logic              R_CLK,
  input  logic              R_RST,
  input  logic              R_INC,
  input  logic              R_CLR_ERR,
  input  logic [ADDR_W:0]   W_PTR_G,
  input  logic [ADDR_W:0]   AE_LEVEL,
  output logic [ADDR_W-1:0] R_addr,
  output logic [ADDR_W:0]   R_ptr,
  output logic              R_POP,
  output logic              R_EMPTY,
  output logic              R_ALMOST_EMPTY,
  output logic [ADDR_W:0]   R_COUNT,
  output logic              R_UNDERFLOW
);

  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
  logic [ADDR_W:0] wq;
  logic [ADDR_W:0] w_bin;
  logic [ADDR_W:0] r_bin_q, r_bin_d;
  logic [ADDR_W:0] r_gray_d;
  logic [ADDR_W:0] r_gray_q;
  logic [ADDR_W:0] count_d;
  logic [ADDR_W:0] count_q;
  logic            empty_q;
  logic            almost_empty_q;
  logic            underflow_q;
  logic            pop;

  // Plain flop chain: no logic between stages so each bit resolves metastability alone.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], W_PTR_G};
    end
  end

  assign wq = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= ADDR_W; gi++) begin : g_g2b
      assign w_bin[gi] = ^wq[ADDR_W:gi];
    end
  endgenerate

  assign pop      = R_INC & ~empty_q & ~R_RST;
  assign r_bin_d  = r_bin_q + {{ADDR_W{1'b0}}, pop};
  assign r_gray_d = r_bin_d ^ (r_bin_d >> 1);
  assign count_d  = w_bin - r_bin_d;

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      r_bin_q        <= '0;
      r_gray_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      r_bin_q        <= r_bin_d;
      r_gray_q       <= r_gray_d;
      count_q        <= count_d;
      empty_q        <= (r_gray_d == wq);
      almost_empty_q <= (count_d <= AE_LEVEL);
      // A new underflow attempt takes priority over a clear in the same cycle.
      if (R_INC && empty_q) begin
        underflow_q <= 1'b1;
      end else if (R_CLR_ERR) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign R_addr         = r_bin_q[ADDR_W-1:0];
  assign R_ptr          = r_gray_q;
  assign R_POP          = pop;
  assign R_EMPTY        = empty_q;
  assign R_ALMOST_EMPTY = almost_empty_q;
  assign R_COUNT        = count_q;
  assign R_UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (depth 8, two sync stages): vector table for reset,
// sync latency, drain and sticky error, then hand-written threshold and wrap-around runs.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       clr;
  logic [3:0] w_ptr_g;
  logic [3:0] ae_level;
  logic [2:0] r_addr;
  logic [3:0] r_ptr;
  logic       r_pop;
  logic       r_empty;
  logic       r_ae;
  logic [3:0] r_count;
  logic       r_uf;

  int checks;
  int failures;
  logic sampled_pop;

  fifo_rd_ctrl #(.MEM_DEPTH(8), .SYNC_STAGES(2)) dut (
    .R_CLK(clk),
    .R_RST(rst),
    .R_INC(inc),
    .R_CLR_ERR(clr),
    .W_PTR_G(w_ptr_g),
    .AE_LEVEL(ae_level),
    .R_addr(r_addr),
    .R_ptr(r_ptr),
    .R_POP(r_pop),
    .R_EMPTY(r_empty),
    .R_ALMOST_EMPTY(r_ae),
    .R_COUNT(r_count),
    .R_UNDERFLOW(r_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, inc, clr;
    logic [3:0] w, ae;
    logic       pop;
    logic       empty, aef;
    logic [3:0] cnt;
    logic [2:0] addr;
    logic [3:0] ptr;
    logic       uf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] g(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic rst_v, input logic inc_v, input logic clr_v,
                              input logic [3:0] w_v, input logic [3:0] ae_v,
                              input logic pop_v, input logic e_v, input logic a_v,
                              input int cnt_v, input int addr_v, input logic [3:0] ptr_v,
                              input logic uf_v);
    vec_t v;
    v.rst = rst_v; v.inc = inc_v; v.clr = clr_v; v.w = w_v; v.ae = ae_v;
    v.pop = pop_v; v.empty = e_v; v.aef = a_v;
    v.cnt = cnt_v[3:0]; v.addr = addr_v[2:0]; v.ptr = ptr_v; v.uf = uf_v;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive at negedge, sample the combinational pop just after, then let one rising edge pass.
  task automatic step(input logic rst_v, input logic inc_v, input logic clr_v,
                      input logic [3:0] w_v, input logic [3:0] ae_v);
    @(negedge clk);
    rst = rst_v; inc = inc_v; clr = clr_v; w_ptr_g = w_v; ae_level = ae_v;
    #1;
    sampled_pop = r_pop;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops;
    int exp_cnt;
    logic [2:0] prev_addr;
    logic [3:0] prev_ptr;
    logic saw_addr_wrap, saw_ptr_wrap;
    logic [3:0] wg;

    checks = 0; failures = 0;
    rst = 1'b1; inc = 1'b0; clr = 1'b0; w_ptr_g = '0; ae_level = 4'd2;

    // Reset held three cycles with a read request and a non-zero write pointer.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, g(5), 2, 0, 1, 1, 0, 0, 0, 0));
    // Write pointer 0 -> 1: flags move on the third edge.
    vecs.push_back(mk(0, 0, 0, g(1), 2, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, g(1), 2, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, g(1), 2, 0, 0, 1, 1, 0, 0, 0));
    // Fill to eight words, then drain with ten requests.
    vecs.push_back(mk(0, 0, 0, g(8), 2, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, g(8), 2, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, g(8), 2, 0, 0, 0, 8, 0, 0, 0));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, 0, g(8), 2, 1, (k == 8), ((8 - k) <= 2), 8 - k, k % 8, g(k), 0));
    vecs.push_back(mk(0, 1, 0, g(8), 2, 0, 1, 1, 0, 0, g(8), 1));
    vecs.push_back(mk(0, 1, 0, g(8), 2, 0, 1, 1, 0, 0, g(8), 1));
    // Sticky error: clear, re-set, set-wins-over-clear, clear.
    vecs.push_back(mk(0, 0, 1, g(8), 2, 0, 1, 1, 0, 0, g(8), 0));
    vecs.push_back(mk(0, 1, 0, g(8), 2, 0, 1, 1, 0, 0, g(8), 1));
    vecs.push_back(mk(0, 1, 1, g(8), 2, 0, 1, 1, 0, 0, g(8), 1));
    vecs.push_back(mk(0, 0, 1, g(8), 2, 0, 1, 1, 0, 0, g(8), 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].w, vecs[i].ae);
      chk($sformatf("v%0d_pop", i), sampled_pop, vecs[i].pop);
      chk($sformatf("v%0d_empty", i), r_empty, vecs[i].empty);
      chk($sformatf("v%0d_almost_empty", i), r_ae, vecs[i].aef);
      chk($sformatf("v%0d_count", i), r_count, vecs[i].cnt);
      chk($sformatf("v%0d_addr", i), r_addr, vecs[i].addr);
      chk($sformatf("v%0d_ptr", i), r_ptr, vecs[i].ptr);
      chk($sformatf("v%0d_underflow", i), r_uf, vecs[i].uf);
      $display("vec %0d: rst=%0b inc=%0b clr=%0b w=%0h pop=%0b empty=%0b ae=%0b cnt=%0d addr=%0d ptr=%0h uf=%0b",
               i, vecs[i].rst, vecs[i].inc, vecs[i].clr, vecs[i].w, sampled_pop,
               r_empty, r_ae, r_count, r_addr, r_ptr, r_uf);
    end

    // Almost-empty threshold 3: occupancy 6 (write at 14, read at 8), pop one per cycle.
    for (int i = 0; i < 3; i++) step(0, 0, 0, g(14), 3);
    chk("ae_fill_count", r_count, 6);
    chk("ae_fill_flag", r_ae, 0);
    chk("ae_fill_empty", r_empty, 0);
    exp_cnt = 6;
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 0, g(14), 3);
      exp_cnt--;
      chk($sformatf("ae_pop%0d_pop", k), sampled_pop, 1);
      chk($sformatf("ae_pop%0d_count", k), r_count, exp_cnt);
      chk($sformatf("ae_pop%0d_flag", k), r_ae, (exp_cnt <= 3));
      chk($sformatf("ae_pop%0d_addr", k), r_addr, (8 + k) % 8);
      $display("ae pop %0d: count=%0d almost_empty=%0b", k, r_count, r_ae);
    end

    // Wrap-around: 40 words written one per two cycles, reads requested every cycle.
    pops = 0; saw_addr_wrap = 1'b0; saw_ptr_wrap = 1'b0;
    for (int s = 1; s <= 46; s++) begin
      wg = (s <= 40) ? g((14 + s) % 16) : g(14 + 40);
      for (int c = 0; c < 2; c++) begin
        prev_addr = r_addr;
        prev_ptr  = r_ptr;
        step(0, 1, 0, wg, 3);
        if (sampled_pop) pops++;
        if (prev_addr == 3'd7 && r_addr == 3'd0) saw_addr_wrap = 1'b1;
        if (prev_ptr == g(15) && r_ptr == 4'd0) saw_ptr_wrap = 1'b1;
        chk("wrap_ptr_bits", $countones(prev_ptr ^ r_ptr), sampled_pop ? 1 : 0);
        chk("wrap_addr_step", r_addr, sampled_pop ? 3'(prev_addr + 3'd1) : prev_addr);
        chk("wrap_count_max", (r_count <= 4'd8), 1);
      end
      $display("wrap step %0d: w=%0h addr=%0d ptr=%0h count=%0d pops=%0d", s, wg, r_addr, r_ptr, r_count, pops);
    end
    chk("wrap_total_pops", pops, 40);
    chk("wrap_addr_wrapped", saw_addr_wrap, 1);
    chk("wrap_rbin_wrapped", saw_ptr_wrap, 1);
    chk("wrap_final_addr", r_addr, 6);
    chk("wrap_final_ptr", r_ptr, g(6));
    chk("wrap_final_empty", r_empty, 1);
    chk("wrap_final_count", r_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
